// File: rtl/obj_sched_pkg.sv
// -----------------------------------------------------------------------------
// obj_sched_pkg
// Shared definitions for the object-RAM write scheduler: default object-RAM
// widths, default requester count and FIFO depth, the scheduler FSM state type
// and a width helper for occupancy counters.
// No ports (package).
// -----------------------------------------------------------------------------
package obj_sched_pkg;

  localparam int OBJ_ADDR_W  = 3;
  localparam int OBJ_DATA_W  = 13;
  localparam int OBJ_NUM_REQ = 3;
  localparam int OBJ_DEPTH   = 4;

  typedef enum logic [0:0] {
    WAIT_VB = 1'b0,
    DRAIN   = 1'b1
  } sched_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/obj_wr_scheduler_if.sv
// -----------------------------------------------------------------------------
// obj_wr_scheduler_if
// Groups the requester handshake bus and the object-RAM write bus.
//   iReq_valid / iReq_addr / iReq_data : packed per-requester requests
//   oReq_ack                           : one-hot accept strobe
//   oObjRam_addr / oObjRam_data / oObjRam_we : registered RAM write port
// Modports: master = game-logic / RAM side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface obj_wr_scheduler_if
  import obj_sched_pkg::*;
#(
  parameter int NUM_REQ = OBJ_NUM_REQ,
  parameter int ADDR_W  = OBJ_ADDR_W,
  parameter int DATA_W  = OBJ_DATA_W
);
  logic [NUM_REQ-1:0]        iReq_valid;
  logic [NUM_REQ*ADDR_W-1:0] iReq_addr;
  logic [NUM_REQ*DATA_W-1:0] iReq_data;
  logic [NUM_REQ-1:0]        oReq_ack;
  logic [ADDR_W-1:0]         oObjRam_addr;
  logic [DATA_W-1:0]         oObjRam_data;
  logic                      oObjRam_we;

  modport master (
    output iReq_valid, iReq_addr, iReq_data,
    input  oReq_ack, oObjRam_addr, oObjRam_data, oObjRam_we
  );

  modport slave (
    input  iReq_valid, iReq_addr, iReq_data,
    output oReq_ack, oObjRam_addr, oObjRam_data, oObjRam_we
  );
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first active request at or above the
// pointer (wrapping). The pointer moves past the winner only when the grant
// is actually accepted downstream.
//   clk, reset : clock, async active-high reset (pointer -> 0)
//   i_req      : request vector
//   i_accept   : grant consumed this cycle
//   o_grant    : one-hot grant (raw, before acceptance)
//   o_idx      : binary index of the granted requester
//   o_valid    : a grant exists
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Search from the pointer upward with wrap; first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

  // Pointer advances to winner+1 (mod NUM_REQ) on an accepted grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_valid && i_accept) begin
      r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end
endmodule

// File: rtl/obj_wr_scheduler.sv
// -----------------------------------------------------------------------------
// obj_wr_scheduler
// Arbitrates object-RAM writes from NUM_REQ requesters into a DEPTH-entry
// FIFO and drains the FIFO only inside the vertical-sync window, one write
// per cycle, so sprites never tear. Also emits a per-frame tick.
//   clk, reset   : CLK_25, async active-high reset
//   iVS          : vertical sync, active low
//   bus (slave)  : request handshake + registered object-RAM write port
//   oFrame_tick  : one-cycle pulse, one cycle after the iVS falling edge
//   oPending     : FIFO occupancy
// Optional build macro OBJWR_COALESCE_EN: a request whose address matches a
// queued (not currently popping) entry overwrites that entry's data instead
// of taking a new slot, and is accepted even when the FIFO is full.
// -----------------------------------------------------------------------------
module obj_wr_scheduler
  import obj_sched_pkg::*;
#(
  parameter int NUM_REQ = OBJ_NUM_REQ,
  parameter int ADDR_W  = OBJ_ADDR_W,
  parameter int DATA_W  = OBJ_DATA_W,
  parameter int DEPTH   = OBJ_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iVS,
  obj_wr_scheduler_if.slave           bus,
  output logic                        oFrame_tick,
  output logic [occ_w(DEPTH)-1:0]     oPending
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_w(DEPTH);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_vs_d, r_frame_tick, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  sched_state_e      r_state, w_state_nxt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_vld;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [DATA_W-1:0]  w_req_data;
  logic               w_vb_start, w_pop, w_push, w_accept, w_hit;
`ifdef OBJWR_COALESCE_EN
  logic [PTR_W-1:0]   w_slot, w_hit_ptr;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.iReq_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_grant_idx),
    .o_valid  (w_grant_vld)
  );

  assign w_vb_start = r_vs_d & ~iVS;
  assign w_req_addr = bus.iReq_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
  assign w_req_data = bus.iReq_data[int'(w_grant_idx)*DATA_W +: DATA_W];
  // Pop decision is made only inside the sync window with data available.
  assign w_pop      = (r_state == DRAIN) & ~iVS & (r_count != '0);

  // Address match against queued entries; the entry leaving this cycle is skipped.
  always_comb begin
    w_hit = 1'b0;
`ifdef OBJWR_COALESCE_EN
    w_slot    = '0;
    w_hit_ptr = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_slot = r_rd_ptr + PTR_W'(j);
      if (!w_hit && (CNT_W'(j) < r_count) && !(j == 0 && w_pop) &&
          (r_mem_addr[w_slot] == w_req_addr)) begin
        w_hit     = 1'b1;
        w_hit_ptr = w_slot;
      end else begin
        w_hit = w_hit;
      end
    end
`endif
  end

  // A full FIFO still accepts when a slot frees up this same cycle.
  assign w_accept     = w_grant_vld & (w_hit | (r_count != FULL_CNT) | w_pop);
  assign w_push       = w_accept & ~w_hit;
  assign bus.oReq_ack = w_grant & {NUM_REQ{w_accept}};

  // Next-state logic: stay in DRAIN while sync is low and work remains or arrives.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_VB: begin
        if (w_vb_start) w_state_nxt = DRAIN;
        else            w_state_nxt = WAIT_VB;
      end
      DRAIN: begin
        if (iVS || (r_count == '0 && !w_push)) w_state_nxt = WAIT_VB;
        else                                   w_state_nxt = DRAIN;
      end
      default: w_state_nxt = WAIT_VB;
    endcase
  end

  // FSM state, vsync edge history and frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_VB;
      r_vs_d       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vs_d       <= iVS;
      r_frame_tick <= w_vb_start;
    end
  end

  // FIFO storage; no reset needed since only counted entries are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= w_req_addr;
      r_mem_data[r_wr_ptr] <= w_req_data;
    end
`ifdef OBJWR_COALESCE_EN
    else if (w_accept) begin
      r_mem_data[w_hit_ptr] <= w_req_data;
    end
`endif
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      else        r_wr_ptr <= r_wr_ptr;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      else        r_rd_ptr <= r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered RAM write port; addr/data hold after the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      r_we   <= 1'b1;
      r_addr <= r_mem_addr[r_rd_ptr];
      r_data <= r_mem_data[r_rd_ptr];
    end else begin
      r_we   <= 1'b0;
      r_addr <= r_addr;
      r_data <= r_data;
    end
  end

  assign bus.oObjRam_we   = r_we;
  assign bus.oObjRam_addr = r_addr;
  assign bus.oObjRam_data = r_data;
  assign oFrame_tick      = r_frame_tick;
  assign oPending         = r_count;
endmodule
